// File: rtl/generador_pkg.sv
// Shared types and constants for the cube launcher: FSM state encoding,
// LFSR tap positions and the speed saturation level.
package generador_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    LANZA  = 2'd2,
    ACTIVO = 2'd3
  } estado_t;

  // Fibonacci LFSR for x^9 + x^5 + 1: feedback from bits 8 and 4.
  localparam int LFSR_W     = 9;
  localparam int LFSR_TAP_A = 8;
  localparam int LFSR_TAP_B = 4;

  localparam logic [1:0] VEL_MAX = 2'd3;

endpackage

// File: rtl/generador_if.sv
// Launch/completion link between the cube generator (master) and one cube (slave).
//
// Handshake: start_cubo is a one-cycle launch pulse; posicion_x_inicial_aleatoria
// and velocidad_cubo are valid in that cycle and held until the next launch.
// terminado_cubo is a one-cycle pulse from the cube when it reaches the bottom.
// Only one cube is in flight at a time, so no ready/backpressure signal exists.
interface generador_if;
  logic       start_cubo;
  logic [8:0] posicion_x_inicial_aleatoria;
  logic [1:0] velocidad_cubo;
  logic       terminado_cubo;

  modport master (
    output start_cubo,
    output posicion_x_inicial_aleatoria,
    output velocidad_cubo,
    input  terminado_cubo
  );

  modport slave (
    input  start_cubo,
    input  posicion_x_inicial_aleatoria,
    input  velocidad_cubo,
    output terminado_cubo
  );
endinterface

// File: rtl/generador_lfsr_posicion.sv
// Free-running 9-bit LFSR with its value folded into the legal range 0..X_MAX.
// The single subtraction fold is valid while X_MAX >= 255.
module lfsr_posicion
  import generador_pkg::*;
#(
  parameter int X_MAX = 448,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 9'h1A5
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [LFSR_W-1:0] candidato
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
    end
  end

  always_comb begin
    candidato = lfsr;
    if (lfsr > LFSR_W'(X_MAX)) begin
      candidato = lfsr - LFSR_W'(X_MAX + 1);
    end
  end

endmodule

// File: rtl/generador_cubos.sv
// Cube launcher: waits SPAWN_DELAY frame ticks, pulses start_cubo with a random x
// and the current speed, then waits for terminado_cubo. Speed rises every
// CUBOS_POR_NIVEL completed cubes. Optional macro: GENERADOR_WATCHDOG_EN.
module generador_cubos
  import generador_pkg::*;
#(
  parameter int X_MAX             = 448,
  parameter int SPAWN_DELAY       = 30,
  parameter int CUBOS_POR_NIVEL   = 8,
  parameter int VELOCIDAD_INICIAL = 1,
  parameter logic [8:0] LFSR_SEED = 9'h1A5
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           juego_activo,
  input  logic           tick_frame,
  generador_if.master    cubo,
  output logic           cubo_en_vuelo,
  output logic [7:0]     cubos_completados,
  output estado_t        estado
`ifdef GENERADOR_WATCHDOG_EN
  ,output logic          watchdog_error
`endif
);

  localparam int         DLY_W  = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
  localparam logic [1:0] VEL_INI = 2'(VELOCIDAD_INICIAL);

  estado_t          estado_d;
  logic [DLY_W-1:0] cnt_delay;
  logic [1:0]       nivel;
  logic [1:0]       velocidad;
  logic [8:0]       posicion_x;
  logic [8:0]       candidato;
  logic [7:0]       cubos_sig;
  logic             empezar, lanzar, fin_cubo, inc_delay, wd_fire;

  lfsr_posicion #(
    .X_MAX     (X_MAX),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset_n   (reset_n),
    .candidato (candidato)
  );

`ifdef GENERADOR_WATCHDOG_EN
  localparam logic [9:0] WD_ULTIMO = 10'd1022;
  logic [9:0] cnt_wd;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) estado <= IDLE;
    else          estado <= estado_d;
  end

  // Dropping juego_activo overrides every state, which is also what makes a
  // terminado_cubo in the same cycle get ignored.
  always_comb begin
    estado_d  = estado;
    empezar   = 1'b0;
    lanzar    = 1'b0;
    fin_cubo  = 1'b0;
    inc_delay = 1'b0;
    wd_fire   = 1'b0;
    if (!juego_activo) begin
      estado_d = IDLE;
    end else begin
      case (estado)
        IDLE: begin
          estado_d = ESPERA;
          empezar  = 1'b1;
        end
        ESPERA: begin
          if (tick_frame) begin
            if (cnt_delay == DLY_W'(SPAWN_DELAY - 1)) begin
              estado_d = LANZA;
              lanzar   = 1'b1;
            end else begin
              inc_delay = 1'b1;
            end
          end
        end
        LANZA: estado_d = ACTIVO;
        ACTIVO: begin
          if (cubo.terminado_cubo) begin
            estado_d = ESPERA;
            fin_cubo = 1'b1;
          end
`ifdef GENERADOR_WATCHDOG_EN
          else if (tick_frame && cnt_wd == WD_ULTIMO) begin
            estado_d = ESPERA;
            wd_fire  = 1'b1;
          end
`endif
        end
        default: estado_d = IDLE;
      endcase
    end
  end

  assign cubos_sig = cubos_completados + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_delay         <= '0;
      cubos_completados <= '0;
      nivel             <= VEL_INI;
      velocidad         <= VEL_INI;
      posicion_x        <= '0;
    end else begin
      if (empezar || lanzar || fin_cubo || wd_fire) cnt_delay <= '0;
      else if (inc_delay)                           cnt_delay <= cnt_delay + 1'b1;

      if (empezar) begin
        cubos_completados <= '0;
        nivel             <= VEL_INI;
        velocidad         <= VEL_INI;
      end else if (fin_cubo) begin
        cubos_completados <= cubos_sig;
        if ((cubos_sig % 8'(CUBOS_POR_NIVEL)) == 8'd0 && nivel < VEL_MAX)
          nivel <= nivel + 2'd1;
      end

      // x and speed are latched only on entry to LANZA and held until the next one.
      if (lanzar) begin
        posicion_x <= candidato;
        velocidad  <= nivel;
      end
    end
  end

`ifdef GENERADOR_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_wd         <= '0;
      watchdog_error <= 1'b0;
    end else begin
      if (lanzar)
        cnt_wd <= '0;
      else if (estado == ACTIVO && juego_activo && tick_frame && !cubo.terminado_cubo)
        cnt_wd <= cnt_wd + 10'd1;

      if (empezar)      watchdog_error <= 1'b0;
      else if (wd_fire) watchdog_error <= 1'b1;
    end
  end
`endif

  always_comb begin
    cubo.start_cubo                   = (estado == LANZA);
    cubo.posicion_x_inicial_aleatoria = posicion_x;
    cubo.velocidad_cubo               = velocidad;
    cubo_en_vuelo                     = (estado == ACTIVO);
  end

endmodule

// File: tb/tb_generador_cubos.sv
// Randomized bench for generador_cubos against an event-level reference model,
// with a launch scoreboard. Watchdog checks compile in with GENERADOR_WATCHDOG_EN.
module tb_generador_cubos;
  import generador_pkg::*;

  localparam int         SD   = 3;
  localparam int         CPN  = 8;
  localparam int         XMAX = 448;
  localparam logic [8:0] SEED = 9'h1A5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       juego_activo = 1'b0;
  logic       tick_frame = 1'b0;
  logic       cubo_en_vuelo;
  logic [7:0] cubos_completados;
  estado_t    estado;
`ifdef GENERADOR_WATCHDOG_EN
  logic       watchdog_error;
`endif

  generador_if cubo_bus ();

  generador_cubos #(
    .X_MAX             (XMAX),
    .SPAWN_DELAY       (SD),
    .CUBOS_POR_NIVEL   (CPN),
    .VELOCIDAD_INICIAL (1),
    .LFSR_SEED         (SEED)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .juego_activo      (juego_activo),
    .tick_frame        (tick_frame),
    .cubo              (cubo_bus),
    .cubo_en_vuelo     (cubo_en_vuelo),
    .cubos_completados (cubos_completados),
    .estado            (estado)
`ifdef GENERADOR_WATCHDOG_EN
    ,.watchdog_error   (watchdog_error)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [8:0] lfsr_next(input logic [8:0] s);
    int v;
    v = int'(s);
    return 9'(((v * 2) % 512) + (((v / 256) ^ (v / 16)) % 2));
  endfunction

  function automatic logic [8:0] fold(input logic [8:0] s);
    return 9'(int'(s) % (XMAX + 1));
  endfunction

  logic [18:0] exp_q[$];
  logic [8:0]  m_lfsr = SEED, m_prev, m_x = '0;
  logic [1:0]  m_nivel = 2'd1, m_vel = 2'd1;
  logic [7:0]  m_count = '0;
  int          m_ticks = 0, m_wd_ticks = 0;
  bit          m_playing = 0, m_launch = 0, m_flight = 0, m_wd = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr = SEED; m_x = '0; m_nivel = 2'd1; m_vel = 2'd1; m_count = '0;
      m_ticks = 0; m_wd_ticks = 0;
      m_playing = 0; m_launch = 0; m_flight = 0; m_wd = 0;
      exp_q.delete();
    end else begin
      m_prev = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      if (!juego_activo) begin
        m_playing = 0; m_launch = 0; m_flight = 0;
      end else if (!m_playing) begin
        m_playing = 1; m_ticks = 0; m_count = '0;
        m_nivel = 2'd1; m_vel = 2'd1; m_wd = 0;
      end else if (m_launch) begin
        m_launch = 0; m_flight = 1; m_wd_ticks = 0;
      end else if (m_flight) begin
        if (cubo_bus.terminado_cubo) begin
          m_count = m_count + 8'd1;
          if ((int'(m_count) % CPN) == 0 && m_nivel < 2'd3) m_nivel = m_nivel + 2'd1;
          m_flight = 0; m_ticks = 0;
        end
`ifdef GENERADOR_WATCHDOG_EN
        else if (tick_frame) begin
          m_wd_ticks++;
          if (m_wd_ticks == 1023) begin
            m_flight = 0; m_ticks = 0; m_wd = 1;
          end
        end
`endif
      end else if (tick_frame) begin
        if (m_ticks == SD - 1) begin
          m_launch = 1;
          m_x      = fold(m_prev);
          m_vel    = m_nivel;
          exp_q.push_back({m_x, m_vel, m_count});
        end else begin
          m_ticks++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [18:0] got;
  always @(negedge clk) begin
    chk("start_timing", cubo_bus.start_cubo, m_launch);
    chk("en_vuelo", cubo_en_vuelo, m_flight);
    chk("completados", cubos_completados, m_count);
    chk("x_held", cubo_bus.posicion_x_inicial_aleatoria, m_x);
    chk("vel_held", cubo_bus.velocidad_cubo, m_vel);
`ifdef GENERADOR_WATCHDOG_EN
    chk("watchdog_error", watchdog_error, m_wd);
`endif
    if (cubo_bus.start_cubo) begin
      chk("x_range", cubo_bus.posicion_x_inicial_aleatoria <= 9'(XMAX), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        got = exp_q.pop_front();
        chk("launch_x", cubo_bus.posicion_x_inicial_aleatoria, got[18:10]);
        chk("launch_vel", cubo_bus.velocidad_cubo, got[9:8]);
        chk("launch_count", cubos_completados, got[7:0]);
      end
    end
  end

  // ---------------- driver ----------------
  int tick_gap = 2;
  int resp     = 0;
  bit resp_en  = 1;

  task automatic step();
    @(posedge clk);
    #1;
    if (tick_gap == 0) begin
      tick_frame = 1'b1;
      tick_gap   = $urandom_range(2, 7);
    end else begin
      tick_frame = 1'b0;
      tick_gap--;
    end
    cubo_bus.terminado_cubo = 1'b0;
    if (resp_en) begin
      if (cubo_bus.start_cubo) begin
        resp = $urandom_range(2, 8);
      end else if (resp > 0) begin
        resp--;
        if (resp == 0) cubo_bus.terminado_cubo = 1'b1;
      end
      if ($urandom_range(0, 40) == 0) cubo_bus.terminado_cubo = 1'b1;
    end
  endtask

  logic [7:0] saved;

  initial begin
    cubo_bus.terminado_cubo = 1'b0;
    repeat (3) step();
    chk("rst_start", cubo_bus.start_cubo, 0);
    chk("rst_x", cubo_bus.posicion_x_inicial_aleatoria, 0);
    chk("rst_vel", cubo_bus.velocidad_cubo, 1);
    chk("rst_count", cubos_completados, 0);
    reset_n = 1'b1;
    step();
    chk("idle_after_reset", estado, IDLE);

    // Long run: speed should step 1 -> 2 -> 3 and saturate.
    juego_activo = 1'b1;
    for (int i = 0; i < 20000 && cubos_completados != 8'd24; i++) step();
    chk("reached_24", cubos_completados, 24);
    for (int i = 0; i < 200 && !cubo_bus.start_cubo; i++) step();
    chk("launch_after_24", cubo_bus.start_cubo, 1);
    chk("vel_saturated", cubo_bus.velocidad_cubo, 3);

    // terminado_cubo coincident with juego_activo falling is ignored.
    resp_en = 0;
    for (int i = 0; i < 200 && !cubo_en_vuelo; i++) step();
    chk("in_flight", cubo_en_vuelo, 1);
    saved = cubos_completados;
    step();
    cubo_bus.terminado_cubo = 1'b1;
    juego_activo = 1'b0;
    step();
    step();
    chk("simul_count", cubos_completados, saved);
    chk("simul_idle", estado, IDLE);

    // Spurious terminado_cubo while waiting does nothing.
    juego_activo = 1'b1;
    step();
    step();
    cubo_bus.terminado_cubo = 1'b1;
    step();
    chk("spurious_count", cubos_completados, 0);
    chk("spurious_espera", estado, ESPERA);

`ifdef GENERADOR_WATCHDOG_EN
    for (int i = 0; i < 20000 && !watchdog_error; i++) step();
    chk("wd_fired", watchdog_error, 1);
    chk("wd_espera", estado, ESPERA);
    resp_en = 1;
    for (int i = 0; i < 200 && !cubo_bus.start_cubo; i++) step();
    chk("wd_relaunch", cubo_bus.start_cubo, 1);
`endif

    // Reset in the middle of a flight returns to reset values asynchronously.
    resp_en = 1;
    for (int i = 0; i < 2000 && cubos_completados < 8'd3; i++) step();
    resp_en = 0;
    for (int i = 0; i < 200 && !cubo_en_vuelo; i++) step();
    chk("pre_reset_flight", cubo_en_vuelo, 1);
    reset_n = 1'b0;
    #1;
    chk("async_start", cubo_bus.start_cubo, 0);
    chk("async_vuelo", cubo_en_vuelo, 0);
    chk("async_count", cubos_completados, 0);
    chk("async_vel", cubo_bus.velocidad_cubo, 1);
    chk("async_x", cubo_bus.posicion_x_inicial_aleatoria, 0);
    chk("async_estado", estado, IDLE);
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("release_idle", estado, IDLE);
    resp_en = 1;
    repeat (60) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/generador_cubos.md
Name: generador_cubos

Overview:
- Initiator side of the cube start/terminado handshake: decides when each falling cube is launched, where it enters horizontally and how fast it falls.
- Issues a one-cycle start pulse with a latched random x position and speed, then waits for the cube's completion pulse before scheduling the next launch.
- Sits between the game-control logic (game enable, frame strobe) and the Cubo instance.
- Tracks completed cubes and raises the speed level as play progresses.

Parameters:
- X_MAX, 448, largest legal initial x position (cube must fit on screen); output x is always 0..X_MAX.
- SPAWN_DELAY, 30, frame ticks between a cube finishing (or game start) and the next launch.
- CUBOS_POR_NIVEL, 8, completed cubes per speed increment.
- VELOCIDAD_INICIAL, 1, speed value after reset and on each game start.
- LFSR_SEED, 9'h1A5, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- juego_activo  in  1  level; high while the game runs.
- tick_frame  in  1  one-cycle strobe per video frame.
- terminado_cubo  in  1  one-cycle pulse from the cube: cube reached the bottom.
- start_cubo  out  1  one-cycle launch pulse to the cube.
- posicion_x_inicial_aleatoria  out  9  x position for the launched cube.
- velocidad_cubo  out  2  speed for the launched cube.
- cubo_en_vuelo  out  1  high while waiting for terminado_cubo.
- cubos_completados  out  8  completed-cube count, wraps 255->0.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - start_cubo=0, x=0, velocidad_cubo=VELOCIDAD_INICIAL.
  - cubo_en_vuelo=0, cubos_completados=0.
  - LFSR=LFSR_SEED, FSM=IDLE, delay counter=0.
- LFSR:
  - 9-bit Fibonacci, polynomial x^9+x^5+1; advances every clk regardless of state.
  - Candidate x = lfsr if lfsr<=X_MAX, else lfsr-(X_MAX+1).
- State IDLE:
  - Outputs quiescent.
  - On juego_activo=1: clear delay counter, reset cubos_completados=0 and velocidad_cubo=VELOCIDAD_INICIAL, go to ESPERA.
- State ESPERA:
  - Delay counter increments on each tick_frame.
  - When the counter reaches SPAWN_DELAY-1 and tick_frame=1, go to LANZA.
  - tick_frame pulses outside ESPERA are ignored.
- State LANZA (exactly one cycle):
  - start_cubo=1.
  - Register the candidate x into posicion_x_inicial_aleatoria on the same edge that enters LANZA, so x is valid in the same cycle as start_cubo.
  - Next state ACTIVO.
- State ACTIVO:
  - cubo_en_vuelo=1.
  - On terminado_cubo=1:
    - cubos_completados+1.
    - If the new count mod CUBOS_POR_NIVEL==0 and speed<3, speed+1 (saturates at 3). The new speed applies from the next launch.
    - Clear delay counter, go to ESPERA.
- x and velocidad_cubo hold stable from LANZA until the next LANZA.
- Boundary and simultaneous-event rules:
  - juego_activo=0 in any state: next state IDLE, start_cubo=0, cubo_en_vuelo=0. Count and speed hold their values.
  - terminado_cubo in the same cycle as juego_activo falling: ignored, no count increment.
  - terminado_cubo outside ACTIVO (including during LANZA): ignored.
  - Latency from terminado_cubo to the next start_cubo is exactly SPAWN_DELAY tick_frame pulses plus 1 clk.
  - Mid-operation reset returns everything to reset values immediately.

Optional Feature:
- Macro GENERADOR_WATCHDOG_EN.
- Defined:
  - ACTIVO counts tick_frame pulses.
  - If 1023 ticks pass without terminado_cubo, the FSM forces ESPERA with no count increment.
  - Extra output watchdog_error (1 bit) is set and stays sticky until reset_n or the next IDLE->ESPERA transition.
- Not defined: no counter, no watchdog_error port; ACTIVO waits indefinitely.

Decomposition:
- Package generador_pkg:
  - FSM state enum (IDLE, ESPERA, LANZA, ACTIVO).
  - LFSR tap constants.
  - Speed saturation constant 2'd3.
- One sub-module: lfsr_posicion (9-bit LFSR plus fold into 0..X_MAX), reused later for other random spawners.

Test Plan:
- Reset: hold reset_n=0 mid-ACTIVO -> all outputs return to reset values asynchronously; after release FSM=IDLE, start_cubo=0.
- Launch timing: SPAWN_DELAY=3, juego_activo=1, tick_frame every 10 clks -> exactly one start_cubo pulse one clk after the 3rd tick; x<=448; velocidad_cubo=1; cubo_en_vuelo=1 the following cycle.
- Speed progression: CUBOS_POR_NIVEL=8, answer each start with terminado_cubo after 5 clks -> speed becomes 2 after 8 cubes, 3 after 16, stays 3 after 24; cubos_completados=24.
- X fold: force LFSR to 9'h1FF -> x=62; force 9'h1C0 -> x=448.
- Simultaneous events: terminado_cubo and juego_activo falling in the same cycle -> count unchanged, FSM IDLE. Spurious terminado_cubo in ESPERA -> no effect.
- Watchdog (GENERADOR_WATCHDOG_EN defined): no terminado_cubo for 1023 ticks -> watchdog_error=1, FSM ESPERA, next launch after SPAWN_DELAY ticks.
